// File: rtl/cpu_bus_pipe.sv
// Registered, priority-arbitrated CPU bus: din > alu > register file, with bus keeper and conflict flags.
// Optional feature: define CPU_BUS_CONFLICT_CNT_EN to build the 8-bit saturating conflict counter.
module cpu_bus_pipe #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  localparam int SEL_W = $clog2(NREG),
  localparam int SRC_W = $clog2(NREG + 2)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     din_en,
  input  logic                     gout,
  input  logic                     rout_en,
  input  logic [SEL_W-1:0]         rout,
  input  logic [DATA_W-1:0]        din,
  input  logic [DATA_W-1:0]        aluout,
  input  logic [NREG*DATA_W-1:0]   regs,
  input  logic                     cnt_clr,
  output logic [DATA_W-1:0]        buswires,
  output logic                     bus_valid,
  output logic [SRC_W-1:0]         bus_src,
  output logic                     conflict,
  output logic                     bad_sel,
  output logic [7:0]               conflict_cnt
);

  logic [DATA_W-1:0] bus_q, bus_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic              vld_q, vld_d;
  logic              conf_q, conf_d;
  logic              bad_q, bad_d;
  logic [DATA_W-1:0] reg_sel;
  logic              rout_ok;
  logic [1:0]        n_req;

  always_comb begin
    reg_sel = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rout == SEL_W'(i)) reg_sel = regs[i*DATA_W +: DATA_W];
    end
  end

  // Indices past NREG exist only when NREG is not a power of two.
  assign rout_ok = (32'(rout) < 32'(NREG));
  assign n_req   = {1'b0, din_en} + {1'b0, gout} + {1'b0, rout_en};

  always_comb begin
    bus_d  = bus_q;
    src_d  = src_q;
    vld_d  = 1'b0;
    bad_d  = 1'b0;
    conf_d = (n_req > 2'd1);
    if (din_en) begin
      bus_d = din;
      src_d = SRC_W'(NREG);
      vld_d = 1'b1;
    end else if (gout) begin
      bus_d = aluout;
      src_d = SRC_W'(NREG + 1);
      vld_d = 1'b1;
    end else if (rout_en) begin
      if (rout_ok) begin
        bus_d = reg_sel;
        src_d = SRC_W'(rout);
        vld_d = 1'b1;
      end else begin
        bus_d = '0;
        bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus_q  <= '0;
      src_q  <= '0;
      vld_q  <= 1'b0;
      conf_q <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      bus_q  <= bus_d;
      src_q  <= src_d;
      vld_q  <= vld_d;
      conf_q <= conf_d;
      bad_q  <= bad_d;
    end
  end

  assign buswires  = bus_q;
  assign bus_src   = src_q;
  assign bus_valid = vld_q;
  assign conflict  = conf_q;
  assign bad_sel   = bad_q;

`ifdef CPU_BUS_CONFLICT_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Clear dominates a same-cycle conflict; count sticks at 255.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                         cnt_d = 8'd0;
    else if (conf_d && cnt_q != 8'hFF)   cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign conflict_cnt   = 8'd0;
`endif

endmodule
